// File: rtl/cm0ik_ahb_sram_ctrl.sv
// AHB-Lite slave front end for a single-port synchronous SRAM/ROM macro.
// Writes post through a one-entry buffer; reads merge any still-buffered bytes.
module cm0ik_ahb_sram_ctrl #(
  parameter int unsigned AWIDTH = 12,
  parameter int unsigned RD_WS  = 0,
  parameter bit          RO     = 1'b0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  input  logic [31:0]       RAMRD,
  output logic [AWIDTH-3:0] RAMAD,
  output logic [31:0]       RAMWD,
  output logic              RAMCS,
  output logic [3:0]        RAMWE,
  output logic              WBUF_PEND
);

  localparam int unsigned WAW   = AWIDTH - 2;
  localparam logic [1:0]  LP_WS = 2'(RD_WS);

  typedef enum logic [1:0] {StIdle, StRdWait, StErr1, StErr2} state_e;

  state_e         r_state, w_state_nxt;
  logic [1:0]     r_cnt, w_cnt_nxt;

  logic           w_acc, w_rd, w_wr, w_load, w_drain;
  logic [WAW-1:0] w_word;
  logic [3:0]     w_mask;
  logic [31:0]    w_wb_data_cur;

  logic           r_wb_valid, r_wb_dphase;
  logic [WAW-1:0] r_wb_addr;
  logic [3:0]     r_wb_mask;
  logic [31:0]    r_wb_data;

  logic           r_snap_hit;
  logic [3:0]     r_snap_mask;
  logic [31:0]    r_snap_data;

  logic           w_unused;
  assign w_unused = ^{HADDR[31:AWIDTH], HTRANS[0], HSIZE[2]};

  // New transfers are only taken while the data phase of the previous one is completing.
  assign w_acc  = HSEL & HREADY & HTRANS[1] & ((r_state == StIdle) | (r_state == StErr2));
  assign w_rd   = w_acc & ~HWRITE;
  assign w_wr   = w_acc & HWRITE;
  assign w_load = w_wr & ~RO;
  assign w_word = HADDR[AWIDTH-1:2];

  always_comb begin
    w_mask = 4'b1111;
    case (HSIZE[1:0])
      2'b00:   w_mask = 4'b0001 << HADDR[1:0];
      2'b01:   w_mask = HADDR[1] ? 4'b1100 : 4'b0011;
      default: w_mask = 4'b1111;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StIdle, StErr2: begin
        w_state_nxt = StIdle;
        if (w_rd && (RD_WS != 0)) begin
          w_state_nxt = StRdWait;
          w_cnt_nxt   = LP_WS;
        end else if (w_wr && RO) begin
          w_state_nxt = StErr1;
        end
      end
      StRdWait: begin
        w_cnt_nxt = r_cnt - 2'd1;
        if (r_cnt == 2'd1) w_state_nxt = StIdle;
      end
      StErr1:  w_state_nxt = StErr2;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= StIdle;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign HREADYOUT = ~((r_state == StRdWait) | (r_state == StErr1));
  assign HRESP     = (r_state == StErr1) | (r_state == StErr2);

  // A read address phase owns the SRAM port; otherwise a valid buffer drains.
  assign w_drain       = r_wb_valid & ~w_rd;
  assign w_wb_data_cur = r_wb_dphase ? HWDATA : r_wb_data;

  assign RAMCS     = w_rd | w_drain;
  assign RAMWE     = w_drain ? r_wb_mask : 4'b0000;
  assign RAMAD     = w_rd ? w_word : r_wb_addr;
  assign RAMWD     = w_wb_data_cur;
  assign WBUF_PEND = r_wb_valid;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wb_valid  <= 1'b0;
      r_wb_dphase <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_mask   <= 4'b0000;
      r_wb_data   <= 32'd0;
    end else begin
      r_wb_dphase <= w_load;
      if (w_load) begin
        r_wb_valid <= 1'b1;
        r_wb_addr  <= w_word;
        r_wb_mask  <= w_mask;
      end else if (w_drain) begin
        r_wb_valid <= 1'b0;
      end
      if (r_wb_dphase) r_wb_data <= HWDATA;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_snap_hit  <= 1'b0;
      r_snap_mask <= 4'b0000;
      r_snap_data <= 32'd0;
    end else if (w_rd) begin
      r_snap_hit  <= r_wb_valid & (w_word == r_wb_addr);
      r_snap_mask <= r_wb_mask;
      r_snap_data <= w_wb_data_cur;
    end
  end

  always_comb begin
    HRDATA = RAMRD;
    for (int b = 0; b < 4; b++) begin
      if (r_snap_hit && r_snap_mask[b]) HRDATA[8*b +: 8] = r_snap_data[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_cm0ik_ahb_sram_ctrl.sv
// Bench for cm0ik_ahb_sram_ctrl: three instances (RD_WS=0, RD_WS=2, RO=1) behind one
// AHB master, each with its own behavioural SRAM; read data checked via a scoreboard queue.
module tb_cm0ik_ahb_sram_ctrl;

  logic        HCLK, HRESETn;
  logic        hsel, hwrite, hready;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans, sel;
  logic [2:0]  hsize;

  logic        hsel_k    [3];
  logic [31:0] hrdata    [3];
  logic        hreadyout [3];
  logic        hresp     [3];
  logic [31:0] ramrd     [3];
  logic [9:0]  ramad     [3];
  logic [31:0] ramwd     [3];
  logic        ramcs     [3];
  logic [3:0]  ramwe     [3];
  logic        wbuf_pend [3];

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q [$];

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  assign hready = hreadyout[sel];

  cm0ik_ahb_sram_ctrl #(.AWIDTH(12), .RD_WS(0), .RO(1'b0)) u_ws0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_k[0]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready), .HRDATA(hrdata[0]),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .RAMRD(ramrd[0]), .RAMAD(ramad[0]),
    .RAMWD(ramwd[0]), .RAMCS(ramcs[0]), .RAMWE(ramwe[0]), .WBUF_PEND(wbuf_pend[0])
  );

  cm0ik_ahb_sram_ctrl #(.AWIDTH(12), .RD_WS(2), .RO(1'b0)) u_ws2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_k[1]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready), .HRDATA(hrdata[1]),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .RAMRD(ramrd[1]), .RAMAD(ramad[1]),
    .RAMWD(ramwd[1]), .RAMCS(ramcs[1]), .RAMWE(ramwe[1]), .WBUF_PEND(wbuf_pend[1])
  );

  cm0ik_ahb_sram_ctrl #(.AWIDTH(12), .RD_WS(0), .RO(1'b1)) u_ro (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_k[2]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready), .HRDATA(hrdata[2]),
    .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]), .RAMRD(ramrd[2]), .RAMAD(ramad[2]),
    .RAMWD(ramwd[2]), .RAMCS(ramcs[2]), .RAMWE(ramwe[2]), .WBUF_PEND(wbuf_pend[2])
  );

  // Synchronous SRAM: read data appears WS+1 cycles after the strobe and then holds.
  for (genvar k = 0; k < 3; k++) begin : g_ram
    localparam int WS = (k == 1) ? 2 : 0;
    logic [31:0] mem  [1024];
    logic [31:0] pipe [3];
    int          we_cnt = 0;

    assign hsel_k[k] = hsel & (sel == 2'(k));
    assign ramrd[k]  = pipe[WS];

    always @(posedge HCLK) begin
      if (ramcs[k] && ramwe[k] == 4'h0) pipe[0] <= mem[ramad[k]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      if (ramcs[k]) begin
        for (int b = 0; b < 4; b++) begin
          if (ramwe[k][b]) mem[ramad[k]][8*b +: 8] <= ramwd[k][8*b +: 8];
        end
      end
    end

    always @(negedge HCLK) begin
      if (ramwe[k] != 4'h0) we_cnt <= we_cnt + 1;
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic probe();
    @(negedge HCLK);
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic bus_xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz);
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
  endtask

  // Leaves the caller at the negedge of the cycle where HREADYOUT is high; -1 on timeout.
  task automatic wait_ready(input int k, output int waits);
    waits = 0;
    probe();
    while (!hreadyout[k]) begin
      if (waits >= 16) begin
        waits = -1;
        return;
      end
      waits++;
      step();
      probe();
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    sel     = 2'd0;
    haddr   = 32'd0;
    hsize   = 3'd2;
    hwdata  = 32'd0;
    bus_idle();
    repeat (2) @(posedge HCLK);
    probe();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (hreadyout[k] !== 1'b1) $display("FAIL reset_hreadyout[%0d] got %b exp 1", k, hreadyout[k]);
      else n_pass++;
      n_checks++;
      if (hresp[k] !== 1'b0) $display("FAIL reset_hresp[%0d] got %b exp 0", k, hresp[k]);
      else n_pass++;
      n_checks++;
      if (ramcs[k] !== 1'b0) $display("FAIL reset_ramcs[%0d] got %b exp 0", k, ramcs[k]);
      else n_pass++;
      n_checks++;
      if (ramwe[k] !== 4'h0) $display("FAIL reset_ramwe[%0d] got %h exp 0", k, ramwe[k]);
      else n_pass++;
      n_checks++;
      if (wbuf_pend[k] !== 1'b0) $display("FAIL reset_pend[%0d] got %b exp 0", k, wbuf_pend[k]);
      else n_pass++;
    end
    step();
    HRESETn = 1'b1;
    probe();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (hreadyout[k] !== 1'b1) $display("FAIL release_hreadyout[%0d] got %b exp 1", k, hreadyout[k]);
      else n_pass++;
    end
  endtask

  task automatic test_write_read_ws0();
    int          waits;
    logic [31:0] exp;
    sel = 2'd0;
    step();
    bus_xfer(1'b1, 32'h10, 3'd2);
    step();
    bus_idle();
    hwdata = 32'hA5A5_1234;
    probe();
    n_checks++;
    if (ramwe[0] !== 4'hF) $display("FAIL wr_drain_we got %h exp f", ramwe[0]);
    else n_pass++;
    n_checks++;
    if (ramad[0] !== 10'h004) $display("FAIL wr_drain_addr got %h exp 004", ramad[0]);
    else n_pass++;
    n_checks++;
    if (ramwd[0] !== 32'hA5A5_1234) $display("FAIL wr_drain_data got %h exp a5a51234", ramwd[0]);
    else n_pass++;
    n_checks++;
    if (wbuf_pend[0] !== 1'b1) $display("FAIL wr_pend_set got %b exp 1", wbuf_pend[0]);
    else n_pass++;
    step();
    hwdata = 32'd0;
    probe();
    n_checks++;
    if (wbuf_pend[0] !== 1'b0) $display("FAIL wr_pend_clr got %b exp 0", wbuf_pend[0]);
    else n_pass++;
    step();
    bus_xfer(1'b0, 32'h10, 3'd2);
    exp_q.push_back(32'hA5A5_1234);
    probe();
    n_checks++;
    if (ramcs[0] !== 1'b1 || ramwe[0] !== 4'h0) $display("FAIL rd_strobe got cs=%b we=%h exp cs=1 we=0", ramcs[0], ramwe[0]);
    else n_pass++;
    step();
    bus_idle();
    wait_ready(0, waits);
    n_checks++;
    if (waits !== 0) $display("FAIL ws0_wait got %0d exp 0", waits);
    else n_pass++;
    exp = exp_q.pop_front();
    n_checks++;
    if (hrdata[0] !== exp) $display("FAIL ws0_rdata got %h exp %h", hrdata[0], exp);
    else n_pass++;
  endtask

  task automatic test_read_ws2();
    int          waits;
    logic [31:0] exp;
    sel = 2'd1;
    g_ram[1].mem[8] <= 32'hDEAD_BEEF;
    step();
    bus_xfer(1'b0, 32'h20, 3'd2);
    exp_q.push_back(32'hDEAD_BEEF);
    step();
    bus_idle();
    wait_ready(1, waits);
    n_checks++;
    if (waits !== 2) $display("FAIL ws2_wait got %0d exp 2", waits);
    else n_pass++;
    exp = exp_q.pop_front();
    n_checks++;
    if (hrdata[1] !== exp) $display("FAIL ws2_rdata got %h exp %h", hrdata[1], exp);
    else n_pass++;
    n_checks++;
    if (hresp[1] !== 1'b0) $display("FAIL ws2_hresp got %b exp 0", hresp[1]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int          waits;
    logic [31:0] exp;
    sel = 2'd0;
    g_ram[0].mem[16] <= 32'h1122_3344;
    step();
    bus_xfer(1'b1, 32'h43, 3'd0);
    step();
    bus_xfer(1'b0, 32'h40, 3'd2);
    hwdata = 32'h7700_0000;
    exp_q.push_back(32'h7722_3344);
    probe();
    n_checks++;
    if (ramwe[0] !== 4'h0 || ramad[0] !== 10'h010) $display("FAIL b2b_rd_port got we=%h ad=%h exp we=0 ad=010", ramwe[0], ramad[0]);
    else n_pass++;
    n_checks++;
    if (wbuf_pend[0] !== 1'b1) $display("FAIL b2b_pend got %b exp 1", wbuf_pend[0]);
    else n_pass++;
    step();
    bus_idle();
    hwdata = 32'd0;
    wait_ready(0, waits);
    exp = exp_q.pop_front();
    n_checks++;
    if (hrdata[0] !== exp) $display("FAIL b2b_merge got %h exp %h", hrdata[0], exp);
    else n_pass++;
    n_checks++;
    if (ramwe[0] !== 4'b1000 || ramwd[0] !== 32'h7700_0000) $display("FAIL b2b_drain got we=%h wd=%h exp we=8 wd=77000000", ramwe[0], ramwd[0]);
    else n_pass++;
    step();
    n_checks++;
    if (g_ram[0].mem[16] !== 32'h7722_3344) $display("FAIL b2b_sram got %h exp 77223344", g_ram[0].mem[16]);
    else n_pass++;
  endtask

  task automatic test_continuous_reads();
    int          base;
    logic [31:0] exp;
    logic [31:0] rd_addr [3];
    rd_addr = '{32'h80, 32'h84, 32'h84};
    sel = 2'd0;
    g_ram[0].mem[32] <= 32'hCAFE_F00D;
    g_ram[0].mem[33] <= 32'h5555_5555;
    step();
    base = g_ram[0].we_cnt;
    bus_xfer(1'b1, 32'h84, 3'd2);
    exp_q.push_back(32'hCAFE_F00D);
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      step();
      bus_xfer(1'b0, rd_addr[i], 3'd2);
      hwdata = (i == 0) ? 32'h1234_5678 : 32'd0;
      probe();
      n_checks++;
      if (wbuf_pend[0] !== 1'b1 || ramwe[0] !== 4'h0) $display("FAIL cont_stall[%0d] got pend=%b we=%h exp pend=1 we=0", i, wbuf_pend[0], ramwe[0]);
      else n_pass++;
      if (i > 0) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (hrdata[0] !== exp) $display("FAIL cont_rdata[%0d] got %h exp %h", i - 1, hrdata[0], exp);
        else n_pass++;
      end
    end
    step();
    bus_idle();
    probe();
    exp = exp_q.pop_front();
    n_checks++;
    if (hrdata[0] !== exp) $display("FAIL cont_rdata[2] got %h exp %h", hrdata[0], exp);
    else n_pass++;
    n_checks++;
    if (ramwe[0] !== 4'hF || ramad[0] !== 10'h021) $display("FAIL cont_drain got we=%h ad=%h exp we=f ad=021", ramwe[0], ramad[0]);
    else n_pass++;
    step();
    probe();
    n_checks++;
    if (wbuf_pend[0] !== 1'b0) $display("FAIL cont_pend_clr got %b exp 0", wbuf_pend[0]);
    else n_pass++;
    n_checks++;
    if (g_ram[0].we_cnt - base !== 1) $display("FAIL cont_we_pulses got %0d exp 1", g_ram[0].we_cnt - base);
    else n_pass++;
  endtask

  task automatic test_ro();
    int          base, waits;
    logic [31:0] exp;
    sel = 2'd2;
    g_ram[2].mem[2] <= 32'h1357_2468;
    step();
    base = g_ram[2].we_cnt;
    bus_xfer(1'b1, 32'h0, 3'd2);
    step();
    bus_idle();
    hwdata = 32'hFFFF_FFFF;
    probe();
    n_checks++;
    if (hreadyout[2] !== 1'b0 || hresp[2] !== 1'b1) $display("FAIL ro_err1 got rdy=%b resp=%b exp rdy=0 resp=1", hreadyout[2], hresp[2]);
    else n_pass++;
    n_checks++;
    if (ramwe[2] !== 4'h0 || wbuf_pend[2] !== 1'b0) $display("FAIL ro_nowrite got we=%h pend=%b exp we=0 pend=0", ramwe[2], wbuf_pend[2]);
    else n_pass++;
    step();
    hwdata = 32'd0;
    bus_xfer(1'b0, 32'h8, 3'd2);
    exp_q.push_back(32'h1357_2468);
    probe();
    n_checks++;
    if (hreadyout[2] !== 1'b1 || hresp[2] !== 1'b1) $display("FAIL ro_err2 got rdy=%b resp=%b exp rdy=1 resp=1", hreadyout[2], hresp[2]);
    else n_pass++;
    step();
    bus_idle();
    wait_ready(2, waits);
    exp = exp_q.pop_front();
    n_checks++;
    if (waits !== 0 || hresp[2] !== 1'b0) $display("FAIL ro_rd_okay got waits=%0d resp=%b exp waits=0 resp=0", waits, hresp[2]);
    else n_pass++;
    n_checks++;
    if (hrdata[2] !== exp) $display("FAIL ro_rdata got %h exp %h", hrdata[2], exp);
    else n_pass++;
    step();
    n_checks++;
    if (g_ram[2].we_cnt - base !== 0) $display("FAIL ro_we_pulses got %0d exp 0", g_ram[2].we_cnt - base);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int base;
    sel = 2'd1;
    g_ram[1].mem[12] <= 32'd0;
    step();
    base = g_ram[1].we_cnt;
    bus_xfer(1'b1, 32'h30, 3'd2);
    step();
    bus_xfer(1'b0, 32'h20, 3'd2);
    hwdata = 32'hFEED_FACE;
    step();
    bus_idle();
    hwdata = 32'd0;
    #1;
    n_checks++;
    if (hreadyout[1] !== 1'b0 || wbuf_pend[1] !== 1'b1) $display("FAIL mid_pre got rdy=%b pend=%b exp rdy=0 pend=1", hreadyout[1], wbuf_pend[1]);
    else n_pass++;
    HRESETn = 1'b0;
    #1;
    n_checks++;
    if (hreadyout[1] !== 1'b1) $display("FAIL mid_rst_rdy got %b exp 1", hreadyout[1]);
    else n_pass++;
    n_checks++;
    if (wbuf_pend[1] !== 1'b0) $display("FAIL mid_rst_pend got %b exp 0", wbuf_pend[1]);
    else n_pass++;
    repeat (2) step();
    HRESETn = 1'b1;
    repeat (4) step();
    n_checks++;
    if (g_ram[1].we_cnt - base !== 0) $display("FAIL mid_we_pulses got %0d exp 0", g_ram[1].we_cnt - base);
    else n_pass++;
    n_checks++;
    if (g_ram[1].mem[12] !== 32'd0) $display("FAIL mid_sram got %h exp 0", g_ram[1].mem[12]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read_ws0();
    test_read_ws2();
    test_back_to_back();
    test_continuous_reads();
    test_ro();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_left got %0d exp 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
